cover_toggle_collector: RTL and testbench
=========================================

Name: cover_toggle_collector

Overview:
- Receiving end of the toggle-coverage valid-vector interface. Where the DPI reporter forwards each asserted valid bit to the simulator, this block records hits in hardware.
- Keeps a sticky covered bitmap and a registered covered-point count.
- Emits each newly covered point's global index exactly once on a valid/ready stream, drained by the formal/FPGA coverage readout path.
- Synthesisable, with no DPI dependency.

Parameters:
- WIDTH, 29, number of cover points (bits of valid); legal range 1..64.
- COVER_INDEX, 0, global index of bit 0; out_index = COVER_INDEX + bit position.
- FIFO_DEPTH, 4, index FIFO entries; power of two, at least 2.
- IDX_W, 64, width of out_index; matches the longint cover index.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- valid  in  WIDTH  per-point hit strobes, sampled every cycle in which reset=0.
- clear  in  1  synchronous coverage clear; flushes all state, same as reset.
- out_valid  out  1  FIFO head holds an index.
- out_ready  in  1  consumer accepts the head.
- out_index  out  IDX_W  COVER_INDEX + bit position of the newly covered point.
- covered  out  WIDTH  sticky hit bitmap.
- covered_count  out  $clog2(WIDTH+1)  popcount of covered.
- all_covered  out  1  1 when covered is all ones.

Behaviour:
- Reset (already decided): one clock; reset is synchronous and active-high.
- Reset zeroes covered, pending, the FIFO, covered_count, out_valid and all_covered. out_index = 0 while the FIFO is empty.
- clear=1 has the same effect as reset on all state. valid is ignored in a reset or clear cycle.
- Cycle N, no reset or clear:
  - new = valid & ~covered.
  - Edge N sets covered |= valid and pending |= new.
  - covered_count takes the popcount of next covered at edge N, so it is registered and consistent with covered in cycle N+1.
- Scanner: every cycle, selects the lowest set bit b of pending.
  - If push is allowed, it writes COVER_INDEX+b into the FIFO and clears pending[b] at the same edge.
  - Push is allowed when FIFO occupancy < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - At most one push per cycle.
- Latency: a first hit in cycle N with an empty FIFO and no lower pending bit gives out_valid=1 in cycle N+2. There is no bypass.
- Index arithmetic: zero-extend b to IDX_W, then add COVER_INDEX modulo 2^IDX_W.
- FIFO: first-in first-out. Pop when out_valid & out_ready.
  - out_index comes straight from the head register, not combinationally from inputs.
  - out_index is stable while out_valid=1 and out_ready=0.
- No loss: pending is a bitmap, so backpressure never drops a hit. Each index is emitted exactly once per reset/clear epoch.
- Emission order:
  - Hits in the same cycle drain lowest bit first.
  - A hit first seen later is emitted after all lower bits pending at that time. It may precede higher bits that are still pending.
- Repeat hits on a covered point have no effect. A point pending, and hit again, is still emitted once.
- Simultaneous events:
  - valid hit on the same bit the scanner pushes this cycle: no re-set, because it is already covered.
  - Push and pop in the same cycle when full: both occur, occupancy unchanged.
- all_covered = &covered (registered state); it asserts in cycle N+1 after the final hit.
- Reset or clear mid-drain discards pending and queued indices; out_valid=0 on the next cycle.
- No X propagation: out_index = 0 when the FIFO is empty.

Test Plan:
- Reset then idle, valid=0 for 10 cycles -> out_valid=0, covered=0, covered_count=0, all_covered=0.
- Single hit: valid=1<<5 for one cycle, COVER_INDEX=1000, out_ready=1 -> out_valid in cycle N+2 with out_index=1005 for one cycle; covered_count=1 at N+1; a repeat hit on bit 5 later produces nothing.
- Burst with backpressure, FIFO_DEPTH=4: valid=all ones (WIDTH=29) in one cycle, out_ready=0 for 20 cycles, then 1 -> FIFO holds 4, then indices COVER_INDEX+0..+28 emitted in order, each exactly once; all_covered=1 at N+1; covered_count=29.
- Stall stability: out_ready toggling 0/1 every cycle during the burst drain -> out_index held constant while stalled; no duplicates; no gaps.
- Interleaved hits: bit 20 at cycle N, bit 3 at N+1, out_ready=1 -> emission order 20, then 3; an early bit 3 while 20 is pending is emitted lower-first.
- Clear mid-drain: after the burst, assert clear while 10 indices are undrained, with valid=1<<2 in the clear cycle -> next cycle out_valid=0, covered=0, count=0; bit 2 not recorded; a subsequent hit on bit 2 is emitted again.

Source files
------------

// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector
//
// Hardware sink for the toggle-coverage valid-vector interface. Every hit
// strobe on `valid` is folded into a sticky covered bitmap. The global index
// of each newly covered point is queued exactly once and offered on a
// valid/ready stream for the coverage readout path.
//
// Ports
//   clock          in   1                 rising-edge clock
//   reset          in   1                 synchronous active-high reset
//   valid          in   WIDTH             per-point hit strobes
//   clear          in   1                 synchronous coverage clear (same as reset)
//   out_valid      out  1                 FIFO head holds an index
//   out_ready      in   1                 consumer accepts the head
//   out_index      out  IDX_W             COVER_INDEX + bit position, 0 when empty
//   covered        out  WIDTH             sticky hit bitmap
//   covered_count  out  $clog2(WIDTH+1)   registered popcount of covered
//   all_covered    out  1                 every point has been hit
module cover_toggle_collector #(
    parameter int              WIDTH       = 29,
    parameter longint unsigned COVER_INDEX = 0,
    parameter int              FIFO_DEPTH  = 4,
    parameter int              IDX_W       = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           valid,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IDX_W-1:0]           out_index,
    output logic [WIDTH-1:0]           covered,
    output logic [$clog2(WIDTH+1)-1:0] covered_count,
    output logic                       all_covered
);

    localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int CW   = $clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0] COVER_BASE = IDX_W'(COVER_INDEX);

    logic [WIDTH-1:0] r_covered;
    logic [WIDTH-1:0] r_pending;
    logic [CW-1:0]    r_covered_count;
    logic [IDX_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CNTW-1:0]  r_count;

    logic             w_flush;
    logic             w_found;
    logic [BW-1:0]    w_bit;
    logic             w_pop;
    logic             w_push;
    logic [WIDTH-1:0] w_push_mask;
    logic [WIDTH-1:0] w_new;
    logic [WIDTH-1:0] w_covered_nxt;
    logic [WIDTH-1:0] w_pending_nxt;
    logic [IDX_W-1:0] w_push_index;

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    // Lowest set pending bit; scanning downward lets the last match win.
    always_comb begin
        w_found = 1'b0;
        w_bit   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_found = 1'b1;
                w_bit   = BW'(i);
            end
        end
    end

    assign w_flush       = reset | clear;
    assign w_pop         = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push        = w_found & ((r_count != CNTW'(FIFO_DEPTH)) | w_pop);
    assign w_push_mask   = w_push ? (WIDTH'(1) << w_bit) : '0;
    assign w_new         = valid & ~r_covered;
    assign w_covered_nxt = r_covered | valid;
    // pending is always a subset of covered, so a bit being pushed can never
    // be re-set by w_new in the same cycle.
    assign w_pending_nxt = (r_pending & ~w_push_mask) | w_new;
    assign w_push_index  = IDX_W'(w_bit) + COVER_BASE;

    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_covered       <= '0;
            r_pending       <= '0;
            r_covered_count <= '0;
            r_rd_ptr        <= '0;
            r_wr_ptr        <= '0;
            r_count         <= '0;
        end else begin
            r_covered       <= w_covered_nxt;
            r_pending       <= w_pending_nxt;
            r_covered_count <= popcount(w_covered_nxt);
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
        end
    end

    // Storage carries no reset; out_index is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (w_push && !w_flush) r_mem[r_wr_ptr] <= w_push_index;
    end

    assign out_valid     = (r_count != '0);
    assign out_index     = out_valid ? r_mem[r_rd_ptr] : '0;
    assign covered       = r_covered;
    assign covered_count = r_covered_count;
    assign all_covered   = &r_covered;

endmodule

// File: tb/tb_cover_toggle_collector.sv
module tb_cover_toggle_collector;

    localparam int W = 29;

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  valid;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_index;
    logic [W-1:0]  covered;
    logic [4:0]    covered_count;
    logic          all_covered;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] valid;
        logic         clr;
        logic         rdy;
        logic         ov;
        logic [63:0]  idx;
        logic [W-1:0] cov;
        logic [4:0]   cnt;
        logic         all;
    } vec_t;

    vec_t vecs [18];

    always #5 clock = ~clock;

    cover_toggle_collector #(
        .WIDTH      (W),
        .COVER_INDEX(1000),
        .FIFO_DEPTH (4),
        .IDX_W      (64)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .valid        (valid),
        .clear        (clear),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .covered      (covered),
        .covered_count(covered_count),
        .all_covered  (all_covered)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] bm(input int n);
        return W'(1) << n;
    endfunction

    // Drain the burst indices 1000+0 .. 1000+(max_pops-1) in order.
    // With toggle=1, out_ready alternates and a stalled head must not move.
    task automatic drain_burst(input bit toggle, input int max_pops);
        int          popped;
        int          cyc;
        logic [63:0] held;
        bit          stalled;
        popped  = 0;
        cyc     = 0;
        held    = '0;
        stalled = 1'b0;
        while (popped < max_pops && cyc < 400) begin
            out_ready = toggle ? cyc[0] : 1'b1;
            if (stalled) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_index", out_index, held);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("drain_idx%0d", popped), out_index, 64'd1000 + 64'(popped));
                popped++;
                stalled = 1'b0;
            end else if (out_valid) begin
                held    = out_index;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            tick();
            cyc++;
        end
        if (popped < max_pops) begin
            n_run++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pops required %0d", popped, max_pops);
        end
    endtask

    task automatic start_burst();
        clear = 1'b1; valid = '0; out_ready = 1'b0;
        tick();
        clear = 1'b0; valid = '1;
        tick();
        valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; valid = '1; out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0; valid = '0; out_ready = 1'b1;
        // Reset state, then 10 idle cycles.
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_covered", 64'(covered), 64'd0);
        chk("rst_index", out_index, 64'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
        chk("idle_covered", 64'(covered), 64'd0);
        chk("idle_count", 64'(covered_count), 64'd0);
        chk("idle_all", {63'd0, all_covered}, 64'd0);

        // valid, clr, rdy | ov, idx, cov, cnt, all  (outputs after the edge)
        vecs[0]  = '{'0,             1'b0, 1'b1, 1'b0, 64'd0,    '0,                        5'd0, 1'b0};
        vecs[1]  = '{bm(5),          1'b0, 1'b1, 1'b0, 64'd0,    bm(5),                     5'd1, 1'b0};
        vecs[2]  = '{'0,             1'b0, 1'b1, 1'b1, 64'd1005, bm(5),                     5'd1, 1'b0};
        vecs[3]  = '{'0,             1'b0, 1'b1, 1'b0, 64'd0,    bm(5),                     5'd1, 1'b0};
        vecs[4]  = '{bm(5),          1'b0, 1'b1, 1'b0, 64'd0,    bm(5),                     5'd1, 1'b0};
        vecs[5]  = '{'0,             1'b0, 1'b1, 1'b0, 64'd0,    bm(5),                     5'd1, 1'b0};
        vecs[6]  = '{bm(20),         1'b0, 1'b1, 1'b0, 64'd0,    bm(5) | bm(20),            5'd2, 1'b0};
        vecs[7]  = '{bm(3),          1'b0, 1'b1, 1'b1, 64'd1020, bm(3) | bm(5) | bm(20),    5'd3, 1'b0};
        vecs[8]  = '{'0,             1'b0, 1'b1, 1'b1, 64'd1003, bm(3) | bm(5) | bm(20),    5'd3, 1'b0};
        vecs[9]  = '{'0,             1'b0, 1'b1, 1'b0, 64'd0,    bm(3) | bm(5) | bm(20),    5'd3, 1'b0};
        vecs[10] = '{bm(7),          1'b1, 1'b1, 1'b0, 64'd0,    '0,                        5'd0, 1'b0};
        vecs[11] = '{bm(20) | bm(25), 1'b0, 1'b0, 1'b0, 64'd0,   bm(20) | bm(25),           5'd2, 1'b0};
        vecs[12] = '{bm(3),          1'b0, 1'b0, 1'b1, 64'd1020, bm(3) | bm(20) | bm(25),   5'd3, 1'b0};
        vecs[13] = '{'0,             1'b0, 1'b0, 1'b1, 64'd1020, bm(3) | bm(20) | bm(25),   5'd3, 1'b0};
        vecs[14] = '{'0,             1'b0, 1'b0, 1'b1, 64'd1020, bm(3) | bm(20) | bm(25),   5'd3, 1'b0};
        vecs[15] = '{'0,             1'b0, 1'b1, 1'b1, 64'd1003, bm(3) | bm(20) | bm(25),   5'd3, 1'b0};
        vecs[16] = '{'0,             1'b0, 1'b1, 1'b1, 64'd1025, bm(3) | bm(20) | bm(25),   5'd3, 1'b0};
        vecs[17] = '{'0,             1'b0, 1'b1, 1'b0, 64'd0,    bm(3) | bm(20) | bm(25),   5'd3, 1'b0};

        for (int i = 0; i < 18; i++) begin
            valid     = vecs[i].valid;
            clear     = vecs[i].clr;
            out_ready = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].ov});
            chk($sformatf("vec%0d_out_index", i), out_index, vecs[i].idx);
            chk($sformatf("vec%0d_covered", i), 64'(covered), 64'(vecs[i].cov));
            chk($sformatf("vec%0d_count", i), 64'(covered_count), 64'(vecs[i].cnt));
            chk($sformatf("vec%0d_all", i), {63'd0, all_covered}, {63'd0, vecs[i].all});
        end
        clear = 1'b0; valid = '0;

        // Burst with 20 cycles of backpressure, then free drain.
        start_burst();
        chk("burst_covered", 64'(covered), 64'(29'h1FFF_FFFF));
        chk("burst_count", 64'(covered_count), 64'd29);
        chk("burst_all", {63'd0, all_covered}, 64'd1);
        chk("burst_first_valid", {63'd0, out_valid}, 64'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_head", out_index, 64'd1000);
        drain_burst(1'b0, 29);
        tick();
        chk("burst_done_valid", {63'd0, out_valid}, 64'd0);
        chk("burst_done_index", out_index, 64'd0);

        // Drain with out_ready toggling every cycle.
        start_burst();
        drain_burst(1'b1, 29);
        out_ready = 1'b1;
        tick();
        chk("toggle_done_valid", {63'd0, out_valid}, 64'd0);

        // Clear with 10 indices still undrained; the clear-cycle hit is ignored.
        start_burst();
        drain_burst(1'b0, 19);
        clear = 1'b1; valid = bm(2); out_ready = 1'b0;
        tick();
        clear = 1'b0; valid = '0;
        chk("clr_out_valid", {63'd0, out_valid}, 64'd0);
        chk("clr_covered", 64'(covered), 64'd0);
        chk("clr_count", 64'(covered_count), 64'd0);
        chk("clr_all", {63'd0, all_covered}, 64'd0);
        tick();
        chk("clr_bit2_ignored", 64'(covered), 64'd0);
        chk("clr_still_empty", {63'd0, out_valid}, 64'd0);
        valid = bm(2);
        tick();
        valid = '0;
        tick();
        chk("rehit_out_valid", {63'd0, out_valid}, 64'd1);
        chk("rehit_index", out_index, 64'd1002);
        chk("rehit_count", 64'(covered_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
